// File: rtl/uart_pkg.sv
// Shared definitions for the UART pair: receiver state encoding, data-length
// codes and the code-to-length mapping used by uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  localparam logic [1:0] CFG_8 = 2'b00;
  localparam logic [1:0] CFG_7 = 2'b01;
  localparam logic [1:0] CFG_6 = 2'b11;
  localparam logic [1:0] CFG_5 = 2'b10;

  function automatic logic [3:0] cfg_to_len(input logic [1:0] code);
    logic [3:0] len;
    case (code)
      CFG_8:   len = 4'd8;
      CFG_7:   len = 4'd7;
      CFG_6:   len = 4'd6;
      CFG_5:   len = 4'd5;
      default: len = 4'd8;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle
// (high) level so a reset release never looks like a start bit.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= {STAGES{1'b1}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / 5..8 data bits LSB first / stop, no parity.
// Emits each good word with a one-cycle valid, bad stop bits with frame_error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_pulse,
  input  logic [1:0] i_configuration,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] SAMPLE_AT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_AT    = CW'((HALF > 0) ? (HALF - 1) : 0);

  logic          w_rxs;
  logic [7:0]    w_word;
  logic [2:0]    w_last_bit;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic [3:0]    r_len;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_error;
  logic          r_busy;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_rx),
    .o_sync  (w_rxs)
  );

  // Bits enter at the top of r_shift, so a short word ends up left-aligned.
  assign w_word     = r_shift >> (4'd8 - r_len);
  assign w_last_bit = 3'(r_len - 4'd1);

  // Frame state machine with registered strobes and data.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_bit_cnt     <= 3'd0;
      r_len         <= 4'd8;
      r_shift       <= 8'h00;
      r_data        <= 8'h00;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_pulse) begin
            r_len <= cfg_to_len(i_configuration);
          end
          if (!w_rxs) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_bit_cnt <= 3'd0;
            // With one clock per bit this cycle already is the start sample.
            r_state   <= (CLKS_PER_BIT == 1) ? DATA : START;
          end
        end
        START: begin
          if (r_cnt == MID_AT) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        DATA: begin
          if (r_cnt == SAMPLE_AT) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[7:1]};
            if (r_bit_cnt == w_last_bit) begin
              r_state <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        STOP: begin
          if (r_cnt == SAMPLE_AT) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_valid <= 1'b1;
              r_data  <= w_word;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1'b1);
          end
        end
        WAIT_HIGH: begin
          // A held-low (break) line must not be taken as a fresh start bit.
          if (w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_frame_error = r_frame_error;
  assign o_busy        = r_busy;

endmodule
